// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the UART byte receiver.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default oversampling ratio: system clocks per UART bit.
    localparam int DEFAULT_CLKS_PER_BIT = 50;

    // Receiver FSM states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } uart_rx_state_t;

    // Counter width able to hold a full bit period without wrapping.
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit) + 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchronizer for a single asynchronous bit.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_byte_rx
//  Purpose  : 8N1 UART receiver. Finds the start-bit mid-point, then samples
//             each data bit and the stop bit one bit period apart. Produces a
//             one-cycle valid pulse for a good frame or a one-cycle frame
//             error pulse when the stop bit is low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_CLK_PERIOD = CLKS_PER_BIT / 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uartrx,
    output logic       o_rxdatval,
    output logic [7:0] o_rxbyte,
    output logic       o_frame_err
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);

    // Terminal counts: a phase lasting N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_CLK_PERIOD - 1);
    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    uart_rx_state_t   state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       bit_q,    bit_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       rxbyte_q, rxbyte_d;
    logic             datval_q, datval_d;
    logic             ferr_q,   ferr_d;

    logic w_rx_sync;
    logic w_half_done;
    logic w_bit_done;

    // The serial line is asynchronous; nothing downstream sees it unsynchronized.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_uartrx),
        .o_q   (w_rx_sync)
    );

    assign w_half_done = (cnt_q == C_HALF_LAST);
    assign w_bit_done  = (cnt_q == C_BIT_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk start, 8 data bits, stop, then one cleanup cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!w_rx_sync) state_d = ST_START;
            end
            ST_START: begin
                // A line already high again at mid-start is a glitch, not a frame.
                if (w_half_done) state_d = w_rx_sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_done && (bit_q == 3'd7)) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_done) state_d = ST_CLEANUP;
            end
            ST_CLEANUP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: counters, bit capture, result pulses.
    always_comb begin
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rxbyte_d = rxbyte_q;
        datval_d = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
            end
            ST_START: begin
                cnt_d = w_half_done ? '0 : (cnt_q + C_CNT_ONE);
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    cnt_d          = '0;
                    shift_d[bit_q] = w_rx_sync;
                    bit_d          = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    cnt_d = '0;
                    // Only a properly framed byte is published; a bad frame leaves
                    // the previous byte visible.
                    if (w_rx_sync) begin
                        rxbyte_d = shift_q;
                        datval_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_CLEANUP: begin
                cnt_d = '0;
                bit_d = 3'd0;
            end
            default: begin
                cnt_d = '0;
                bit_d = 3'd0;
            end
        endcase
    end

    // Datapath registers; reset aborts any frame in flight without a pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            rxbyte_q <= 8'h00;
            datval_q <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rxbyte_q <= rxbyte_d;
            datval_q <= datval_d;
            ferr_q   <= ferr_d;
        end
    end

    assign o_rxdatval  = datval_q;
    assign o_rxbyte    = rxbyte_q;
    assign o_frame_err = ferr_q;

endmodule : uart_byte_rx
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_byte_rx
//  Purpose  : Directed, table-driven bench for uart_byte_rx at default timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_rx;

    localparam int CPB     = 50;
    localparam int HALF    = 25;
    localparam int LAT_NOM = HALF + 9 * CPB + 3;

    logic       clk;
    logic       rst;
    logic       uartrx;
    logic       o_rxdatval;
    logic [7:0] o_rxbyte;
    logic       o_frame_err;

    int n_vec;
    int n_err;
    int cyc;
    int n_valid;
    int n_ferr;
    int n_viol;
    int last_valid_cyc;
    logic       prev_val;
    logic       prev_ferr;
    logic [7:0] prev_byte;

    typedef struct {
        logic [7:0] data;
        bit         stop_hi;
        int         gap_bits;
        int         exp_valid;
        logic [7:0] exp_byte;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[8];

    uart_byte_rx #(
        .CLKS_PER_BIT    (CPB),
        .HALF_CLK_PERIOD (HALF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uartrx    (uartrx),
        .o_rxdatval  (o_rxdatval),
        .o_rxbyte    (o_rxbyte),
        .o_frame_err (o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor: counts pulses and flags protocol violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_rxdatval) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
            if (o_frame_err) n_ferr++;
            if (o_rxdatval && o_frame_err) n_viol++;
            if (o_rxdatval && prev_val) n_viol++;
            if (o_frame_err && prev_ferr) n_viol++;
            if ((o_rxbyte != prev_byte) && !o_rxdatval) n_viol++;
        end
        prev_val  = o_rxdatval;
        prev_ferr = o_frame_err;
        prev_byte = o_rxbyte;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if ((act < lo) || (act > hi)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        uartrx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Caller is positioned at a negedge; frame starts immediately.
    task automatic send_frame(input logic [7:0] b, input bit stop_hi, output int st);
        uartrx = 1'b0;
        st = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uartrx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uartrx = stop_hi;
        repeat (CPB) @(negedge clk);
        uartrx = 1'b1;
    endtask

    initial begin
        int v0, f0, st;
        n_vec = 0; n_err = 0; cyc = 0;
        n_valid = 0; n_ferr = 0; n_viol = 0; last_valid_cyc = 0;
        prev_val = 1'b0; prev_ferr = 1'b0; prev_byte = 8'h00;

        //        data   stop gap valid byte   ferr
        vecs[0] = '{8'hA5, 1'b1, 2, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
        vecs[3] = '{8'h55, 1'b1, 2, 1, 8'h55, 0};
        vecs[4] = '{8'h12, 1'b1, 2, 1, 8'h12, 0};
        vecs[5] = '{8'h34, 1'b0, 2, 0, 8'h12, 1};
        vecs[6] = '{8'h80, 1'b1, 0, 1, 8'h80, 0};
        vecs[7] = '{8'h01, 1'b1, 2, 1, 8'h01, 0};

        // Reset state.
        rst = 1'b1;
        uartrx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rxbyte", int'(o_rxbyte), 0);
        chk("reset_datval", int'(o_rxdatval), 0);
        chk("reset_ferr", int'(o_frame_err), 0);
        rst = 1'b0;
        idle(2 * CPB);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(vecs[i].data, vecs[i].stop_hi, st);
            chk($sformatf("vec%0d_valid_count", i), n_valid - v0, vecs[i].exp_valid);
            chk($sformatf("vec%0d_ferr_count", i), n_ferr - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_rxbyte", i), int'(o_rxbyte), int'(vecs[i].exp_byte));
            if (vecs[i].exp_valid == 1)
                chk_range($sformatf("vec%0d_latency", i), last_valid_cyc - st, LAT_NOM - 1, LAT_NOM + 1);
            idle(vecs[i].gap_bits * CPB);
        end

        // Short low glitch is rejected; following frame still received.
        v0 = n_valid; f0 = n_ferr;
        uartrx = 1'b0;
        repeat (10) @(negedge clk);
        idle(2 * CPB);
        chk("glitch_valid_count", n_valid - v0, 0);
        chk("glitch_ferr_count", n_ferr - f0, 0);
        send_frame(8'h3C, 1'b1, st);
        chk("after_glitch_valid_count", n_valid - v0, 1);
        chk("after_glitch_rxbyte", int'(o_rxbyte), 'h3C);
        idle(2 * CPB);

        // Break: line low for one 10-bit period gives one frame error, no valid.
        v0 = n_valid; f0 = n_ferr;
        uartrx = 1'b0;
        repeat (10 * CPB) @(negedge clk);
        idle(3 * CPB);
        chk("break_valid_count", n_valid - v0, 0);
        chk("break_ferr_count", n_ferr - f0, 1);
        chk("break_rxbyte", int'(o_rxbyte), 'h3C);

        // Reset during data bit 4 aborts the frame.
        v0 = n_valid; f0 = n_ferr;
        uartrx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uartrx = (8'hC3 >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        uartrx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midreset_rxbyte", int'(o_rxbyte), 0);
        chk("midreset_datval", int'(o_rxdatval), 0);
        chk("midreset_ferr", int'(o_frame_err), 0);
        idle(12 * CPB);
        chk("midreset_valid_count", n_valid - v0, 0);
        chk("midreset_ferr_count", n_ferr - f0, 0);
        send_frame(8'hC3, 1'b1, st);
        chk("postreset_valid_count", n_valid - v0, 1);
        chk("postreset_rxbyte", int'(o_rxbyte), 'hC3);
        chk_range("postreset_latency", last_valid_cyc - st, LAT_NOM - 1, LAT_NOM + 1);
        idle(2 * CPB);

        chk("protocol_violations", n_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_byte_rx
`default_nettype wire
